// File: rtl/build_bucket_insert_pkg.sv
// Shared build-side definitions: NULL pointer, node-word layout and FSM state codes.
package build_bucket_insert_pkg;

    localparam int DEF_NODE_BITS = 16;
    localparam int DEF_TUPLE_W   = 64;

    localparam logic [DEF_NODE_BITS-1:0] NULL_PTR = '1;

    // Node word is {next, key, payload}; next sits above the tuple.
    localparam int PAY_LSB  = 0;
    localparam int PAY_MSB  = 31;
    localparam int KEY_LSB  = 32;
    localparam int KEY_MSB  = 63;
    localparam int NEXT_LSB = DEF_TUPLE_W;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/build_bucket_insert_if.sv
// Tuple input stream and node-memory write stream of the build insert block.
interface build_bucket_insert_if #(
    parameter int NODE_BITS = 16,
    parameter int TUPLE_W   = 64
);
    logic                         ready;
    logic                         valid_in;
    logic [63:0]                  hash_in;
    logic [TUPLE_W-1:0]           tuple_in;
    logic                         node_wr_valid;
    logic [NODE_BITS-1:0]         node_wr_addr;
    logic [NODE_BITS+TUPLE_W-1:0] node_wr_data;

    modport master (
        input  ready,
        output valid_in, hash_in, tuple_in,
        input  node_wr_valid, node_wr_addr, node_wr_data
    );

    modport slave (
        output ready,
        input  valid_in, hash_in, tuple_in,
        output node_wr_valid, node_wr_addr, node_wr_data
    );
endinterface

// File: rtl/build_bucket_insert_head_ram.sv
// Bucket head-pointer RAM: one write port, one registered read port,
// read-during-write to the same entry returns the old contents.
module bucket_head_ram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= '0;
        else
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/build_bucket_insert.sv
// Chained hash-table build: clears bucket heads, then links each incoming
// tuple in front of its bucket chain and streams the node to node memory.
module build_bucket_insert
    import build_bucket_insert_pkg::*;
#(
    parameter int BUCKET_BITS = 10,
    parameter int NODE_BITS   = 16,
    parameter int TUPLE_W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    build_bucket_insert_if.slave   bus,
    input  logic [BUCKET_BITS-1:0] head_rd_addr,
    output logic [NODE_BITS-1:0]   head_rd_data,
    input  logic                   build_done,
    output logic [NODE_BITS:0]     tuple_count,
    output logic                   overflow
);
    localparam logic [NODE_BITS-1:0] NULL_P = '1;

    logic [1:0]                   r_state;
    logic [BUCKET_BITS-1:0]       r_clr_idx;
    logic                         r_drain;
    logic [NODE_BITS-1:0]         r_alloc;
    logic                         r_ovf;
    logic [NODE_BITS:0]           r_cnt;
    logic                         r_s1_valid;
    logic [BUCKET_BITS-1:0]       r_s1_bkt;
    logic [TUPLE_W-1:0]           r_s1_tuple;
    logic [NODE_BITS-1:0]         r_s1_ptr;
    logic                         r_fwd_hit;
    logic [NODE_BITS-1:0]         r_fwd_ptr;
    logic                         r_wr_valid;
    logic [NODE_BITS-1:0]         r_wr_addr;
    logic [NODE_BITS+TUPLE_W-1:0] r_wr_data;

    logic                         w_ready;
    logic [BUCKET_BITS-1:0]       w_in_bkt;
    logic                         w_take;
    logic                         w_accept;
    logic                         w_drop;
    logic                         w_we;
    logic [BUCKET_BITS-1:0]       w_waddr;
    logic [NODE_BITS-1:0]         w_wdata;
    logic [BUCKET_BITS-1:0]       w_raddr;
    logic [NODE_BITS-1:0]         w_rdata;
    logic [NODE_BITS-1:0]         w_next;
    logic                         w_unused_hash;

    assign w_unused_hash = ^bus.hash_in;
    assign w_in_bkt = bus.hash_in[BUCKET_BITS-1:0];
    assign w_ready  = (r_state == ST_RUN) && !r_ovf;
    assign w_take   = bus.valid_in && w_ready;
    assign w_accept = w_take && (r_alloc != NULL_P);
    assign w_drop   = w_take && (r_alloc == NULL_P);

    // The S1 head write lands on the same edge as the next tuple's read,
    // so a same-bucket follower must take the pointer from the pipeline.
    assign w_next  = r_fwd_hit ? r_fwd_ptr : w_rdata;
    assign w_we    = (r_state == ST_CLEAR) || r_s1_valid;
    assign w_waddr = (r_state == ST_CLEAR) ? r_clr_idx : r_s1_bkt;
    assign w_wdata = (r_state == ST_CLEAR) ? NULL_P : r_s1_ptr;
    assign w_raddr = (r_state == ST_DONE) ? head_rd_addr : w_in_bkt;

    bucket_head_ram #(
        .AW(BUCKET_BITS),
        .DW(NODE_BITS)
    ) u_heads (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(w_raddr),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_drain   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == '1)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (build_done && !bus.valid_in) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain)
                        r_state <= ST_DONE;
                end
                default: r_state <= ST_DONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc    <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_bkt   <= '0;
            r_s1_tuple <= '0;
            r_s1_ptr   <= '0;
            r_fwd_hit  <= 1'b0;
            r_fwd_ptr  <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_bkt   <= w_in_bkt;
                r_s1_tuple <= bus.tuple_in;
                r_s1_ptr   <= r_alloc;
                r_fwd_hit  <= r_s1_valid && (r_s1_bkt == w_in_bkt);
                r_fwd_ptr  <= r_s1_ptr;
                r_alloc    <= r_alloc + 1'b1;
            end
            if (w_drop)
                r_ovf <= 1'b1;
            r_wr_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_wr_addr <= r_s1_ptr;
                r_wr_data <= {w_next, r_s1_tuple};
                r_cnt     <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.ready         = w_ready;
    assign bus.node_wr_valid = r_wr_valid;
    assign bus.node_wr_addr  = r_wr_addr;
    assign bus.node_wr_data  = r_wr_data;
    assign head_rd_data      = w_rdata;
    assign tuple_count       = r_cnt;
    assign overflow          = r_ovf;
endmodule

// File: tb/tb_build_bucket_insert.sv
// Directed bench for build_bucket_insert with 16 buckets and 16-entry node space.
module tb_build_bucket_insert;
    logic       clk;
    logic       rst;
    logic [3:0] head_rd_addr;
    logic [3:0] head_rd_data;
    logic       build_done;
    logic [4:0] tuple_count;
    logic       overflow;

    int vectors;
    int miscompares;

    logic [3:0]  wr_addr_q [$];
    logic [3:0]  wr_next_q [$];
    logic [63:0] wr_tup_q  [$];

    build_bucket_insert_if #(.NODE_BITS(4), .TUPLE_W(64)) bus ();

    build_bucket_insert #(
        .BUCKET_BITS(4),
        .NODE_BITS  (4),
        .TUPLE_W    (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .head_rd_addr(head_rd_addr),
        .head_rd_data(head_rd_data),
        .build_done  (build_done),
        .tuple_count (tuple_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.node_wr_valid === 1'b1) begin
            wr_addr_q.push_back(bus.node_wr_addr);
            wr_next_q.push_back(bus.node_wr_data[67:64]);
            wr_tup_q.push_back(bus.node_wr_data[63:0]);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        wr_addr_q.delete();
        wr_next_q.delete();
        wr_tup_q.delete();
    endtask

    task automatic send(input logic [63:0] h, input logic [63:0] t);
        bus.valid_in = 1'b1;
        bus.hash_in  = h;
        bus.tuple_in = t;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic pulse_done();
        build_done = 1'b1;
        @(posedge clk);
        #1;
        build_done = 1'b0;
        idle(4);
    endtask

    task automatic read_head(input logic [3:0] b, output logic [3:0] d);
        head_rd_addr = b;
        @(posedge clk);
        #1;
        d = head_rd_data;
    endtask

    task automatic reset_dut();
        int n;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        build_done = 1'b0;
        idle(2);
        rst = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 64) begin
            idle(1);
            n++;
        end
        vectors++;
        if (bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", bus.ready, n);
        end
        clear_q();
    endtask

    task automatic test_reset();
        int n;
        logic [3:0] d;
        int bad;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        build_done = 1'b0;
        idle(2);
        vectors++;
        if ({bus.ready, bus.node_wr_valid, bus.node_wr_addr, tuple_count, overflow, head_rd_data} !== 16'h0
            || bus.node_wr_data !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_values: rdy=%b wv=%b wa=%h wd=%h cnt=%0d ovf=%b hd=%h, required all 0",
                     bus.ready, bus.node_wr_valid, bus.node_wr_addr, bus.node_wr_data,
                     tuple_count, overflow, head_rd_data);
        end
        rst = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 64) begin
            idle(1);
            n++;
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL ready_rise: ready rose after %0d cycles, required 16", n);
        end
        pulse_done();
        bad = 0;
        for (int b = 0; b < 16; b++) begin
            read_head(b[3:0], d);
            if (d !== 4'hF) begin
                bad++;
                $display("FAIL idle_head: bucket %0d head=%h, required f", b, d);
            end
        end
        vectors++;
        if (bad != 0)
            miscompares++;
    endtask

    task automatic test_basic();
        logic [3:0] hs [4];
        logic [3:0] en [4];
        logic [3:0] d;
        hs[0] = 4'd3; hs[1] = 4'd5; hs[2] = 4'd3; hs[3] = 4'd3;
        en[0] = 4'hF; en[1] = 4'hF; en[2] = 4'h0; en[3] = 4'h2;
        reset_dut();
        for (int i = 0; i < 4; i++)
            send({60'h0ABC, hs[i]}, {32'h1000 + i, 32'hA0 + i});
        idle(4);
        vectors++;
        if (wr_addr_q.size() != 4) begin
            miscompares++;
            $display("FAIL basic_nwrites: %0d writes, required 4", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wr_addr_q[i] !== i[3:0] || wr_next_q[i] !== en[i]
                    || wr_tup_q[i] !== {32'h1000 + i, 32'hA0 + i}) begin
                    miscompares++;
                    $display("FAIL basic_write%0d: addr=%h next=%h tup=%h, required addr=%h next=%h",
                             i, wr_addr_q[i], wr_next_q[i], wr_tup_q[i], i[3:0], en[i]);
                end
            end
        end
        vectors++;
        if (tuple_count !== 5'd4) begin
            miscompares++;
            $display("FAIL basic_count: count=%0d, required 4", tuple_count);
        end
        pulse_done();
        read_head(4'd3, d);
        vectors++;
        if (d !== 4'h3) begin
            miscompares++;
            $display("FAIL basic_head3: head=%h, required 3", d);
        end
        read_head(4'd5, d);
        vectors++;
        if (d !== 4'h1) begin
            miscompares++;
            $display("FAIL basic_head5: head=%h, required 1", d);
        end
        read_head(4'd0, d);
        vectors++;
        if (d !== 4'hF) begin
            miscompares++;
            $display("FAIL basic_head0: head=%h, required f", d);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_next;
        reset_dut();
        for (int i = 0; i < 16; i++)
            send(64'h7, {32'h7000 + i, 32'h0 + i});
        idle(4);
        vectors++;
        if (wr_addr_q.size() != 15) begin
            miscompares++;
            $display("FAIL ovf_nwrites: %0d writes, required 15", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                exp_next = (i == 0) ? 4'hF : 4'(i - 1);
                vectors++;
                if (wr_addr_q[i] !== i[3:0] || wr_next_q[i] !== exp_next) begin
                    miscompares++;
                    $display("FAIL ovf_write%0d: addr=%h next=%h, required addr=%h next=%h",
                             i, wr_addr_q[i], wr_next_q[i], i[3:0], exp_next);
                end
            end
        end
        vectors++;
        if (overflow !== 1'b1 || bus.ready !== 1'b0 || tuple_count !== 5'd15) begin
            miscompares++;
            $display("FAIL ovf_status: ovf=%b ready=%b count=%0d, required 1 0 15",
                     overflow, bus.ready, tuple_count);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] en [3];
        en[0] = 4'hF; en[1] = 4'h0; en[2] = 4'h1;
        reset_dut();
        send(64'h19, 64'h1);
        idle(1);
        send(64'h29, 64'h2);
        idle(2);
        send(64'h39, 64'h3);
        idle(4);
        vectors++;
        if (wr_addr_q.size() != 3) begin
            miscompares++;
            $display("FAIL gap_nwrites: %0d writes, required 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (wr_addr_q[i] !== i[3:0] || wr_next_q[i] !== en[i]) begin
                    miscompares++;
                    $display("FAIL gap_write%0d: addr=%h next=%h, required addr=%h next=%h",
                             i, wr_addr_q[i], wr_next_q[i], i[3:0], en[i]);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        int n;
        reset_dut();
        send(64'h2, 64'h21);
        send(64'h2, 64'h22);
        rst = 1'b1;
        idle(1);
        clear_q();
        idle(1);
        rst = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 64) begin
            idle(1);
            n++;
        end
        vectors++;
        if (n != 16 || wr_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_clear: ready after %0d cycles, %0d writes, required 16 and 0",
                     n, wr_addr_q.size());
        end
        vectors++;
        if (tuple_count !== 5'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_status: count=%0d ovf=%b, required 0 0", tuple_count, overflow);
        end
        send(64'h2, 64'h23);
        idle(4);
        vectors++;
        if (wr_addr_q.size() != 1) begin
            miscompares++;
            $display("FAIL rst_mid_nwrites: %0d writes, required 1", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 4'h0 || wr_next_q[0] !== 4'hF) begin
            miscompares++;
            $display("FAIL rst_mid_write: addr=%h next=%h, required 0 f", wr_addr_q[0], wr_next_q[0]);
        end
    endtask

    task automatic test_ignore();
        rst = 1'b1;
        bus.valid_in = 1'b0;
        build_done = 1'b0;
        idle(2);
        rst = 1'b0;
        clear_q();
        bus.valid_in = 1'b1;
        bus.hash_in = 64'h3;
        bus.tuple_in = 64'h33;
        idle(8);
        bus.valid_in = 1'b0;
        idle(10);
        vectors++;
        if (wr_addr_q.size() != 0 || tuple_count !== 5'd0 || bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ign_clear: %0d writes count=%0d ready=%b, required 0 0 1",
                     wr_addr_q.size(), tuple_count, bus.ready);
        end
        pulse_done();
        bus.valid_in = 1'b1;
        idle(4);
        bus.valid_in = 1'b0;
        idle(3);
        vectors++;
        if (wr_addr_q.size() != 0 || tuple_count !== 5'd0 || bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_done: %0d writes count=%0d ready=%b, required 0 0 0",
                     wr_addr_q.size(), tuple_count, bus.ready);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        build_done = 1'b0;
        head_rd_addr = 4'h0;
        bus.valid_in = 1'b0;
        bus.hash_in = 64'h0;
        bus.tuple_in = 64'h0;
        test_reset();
        test_basic();
        test_overflow();
        test_gaps();
        test_rst_mid();
        test_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/build_bucket_insert.md
Name: build_bucket_insert

Overview:
- Downstream neighbour of the build-side hash stage; consumes one (hash, tuple) pair per cycle and inserts the tuple into a chained hash table.
- Holds the bucket head-pointer table in internal RAM.
- Streams node writes `{next_ptr, tuple}` to external node memory at a bump-allocated address.
- The probe engine later walks the chains from the heads.

Parameters:
- BUCKET_BITS, 10, log2 of bucket count; bucket = hash_in[BUCKET_BITS-1:0].
- NODE_BITS, 16, node address width; all-ones is the NULL pointer, so usable nodes are 0 .. 2^NODE_BITS-2.
- TUPLE_W, 64, tuple width (key in upper 32, payload in lower 32).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when the block accepts valid_in; upstream must hold valid_in low while ready is low.
- valid_in  in  1  hash_in/tuple_in valid this cycle.
- hash_in  in  64  hash value; only bits [BUCKET_BITS-1:0] are used.
- tuple_in  in  TUPLE_W  tuple, cycle-aligned with hash_in by upstream.
- node_wr_valid  out  1  node write strobe.
- node_wr_addr  out  NODE_BITS  node address.
- node_wr_data  out  NODE_BITS+TUPLE_W  {next_ptr, tuple}.
- head_rd_addr  in  BUCKET_BITS  probe-side head lookup address; valid only in DONE.
- head_rd_data  out  NODE_BITS  head pointer, 1 cycle after head_rd_addr.
- build_done  in  1  pulse: the build stream is finished.
- tuple_count  out  NODE_BITS+1  number of tuples inserted.
- overflow  out  1  sticky: a tuple was dropped because node space ran out.

Behaviour:
- Reset values: ready=0, node_wr_valid=0, node_wr_addr=0, node_wr_data=0, tuple_count=0, overflow=0, head_rd_data=0. State=CLEAR, clear index=0, alloc pointer=0.
- CLEAR:
  - writes NULL to head[i] for i=0..2^BUCKET_BITS-1, one entry per cycle, ready=0.
  - After the last entry, go to RUN.
  - ready rises exactly 2^BUCKET_BITS cycles after rst deasserts.
- RUN: ready=1; each valid_in is processed in a 2-stage pipeline.
  - S1 (cycle after accept): register bucket, tuple and alloc pointer P; issue the synchronous head RAM read; increment the alloc pointer.
  - S2: next = old head[bucket], or the forwarded pointer (see below). Write head[bucket]=P. Assert node_wr_valid with addr=P and data={next, tuple}. Increment tuple_count.
  - Latency: valid_in to node_wr_valid is 2 cycles.
  - Throughput: 1 tuple/cycle, with no bubbles for any bucket sequence.
- Forwarding:
  - If an S2 head write targets the same bucket whose read is in flight (the head RAM returns old data on read-during-write), the newer pointer is forwarded.
  - Back-to-back tuples to the same bucket therefore chain correctly: the second tuple's next equals the first tuple's address.
- Full:
  - When the alloc pointer equals 2^NODE_BITS-1 (NULL), the tuple at input is dropped: no node write, no head update, count unchanged.
  - overflow is set and stays set until rst; ready drops to 0 the cycle after overflow sets.
  - In-flight tuples already past input still complete.
- build_done:
  - Accepted in RUN when valid_in=0; the pipeline drains in 2 cycles, then state goes to DONE.
  - In DONE, ready=0 and the head RAM read port serves head_rd_addr.
  - build_done in any other state is ignored.
- valid_in while ready=0: ignored, with no side effects.
- rst mid-operation: discard the pipeline, return to CLEAR, zero the counters and overflow; heads are re-cleared.
- All arithmetic is unsigned. The alloc pointer never wraps; it saturates at NULL.

Decomposition:
- Shared build package holds:
  - NULL_PTR constant (all-ones of NODE_BITS);
  - the node-word layout offsets: next in the upper NODE_BITS, key [63:32], payload [31:0];
  - the state encoding CLEAR / RUN / DONE.
- One natural sub-module: bucket_head_ram, a simple dual-port RAM (1 write, 1 synchronous read, read-during-write returns old data). Its read address is muxed between the pipeline and head_rd_addr by state.

Test Plan (BUCKET_BITS=4, NODE_BITS=4 unless noted):
- Reset, then idle: ready rises on cycle 16 after rst falls; head_rd after build_done returns 0xF for all 16 buckets.
- Insert hashes 3, 5, 3, 3 back-to-back:
  - node writes {addr, next} = (0,F), (1,F), (2,0), (3,2);
  - then build_done and head_rd(3) = 3, head_rd(5) = 1.
- Insert 15 tuples to bucket 7, then a 16th:
  - writes addr 0..14 each linking to the previous; the 16th is dropped;
  - overflow=1, ready=0, tuple_count=15.
- Same-bucket burst with gaps (hash 9, idle, 9, idle, idle, 9): next fields 0xF, 0, 1; forwarding and RAM paths agree.
- Assert rst during the S2 of tuple 2: no further node writes; CLEAR repeats; count=0, overflow=0; a subsequent insert to bucket 2 gets addr 0, next 0xF.
- valid_in while in CLEAR and in DONE: no node_wr_valid, count unchanged.
